// File: rtl/moore_seq_scheduler_pkg.sv
// moore_seq_pkg: shared FSM state type, default sizes and index-width helper for the scheduler
package moore_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/moore_seq_scheduler_if.sv
// moore_seq_if: bundles requester (req_valid/req_data/req_ready), FSM (fsm_reset/fsm_in/fsm_out), result (res_valid/res_ready/res_id/res_count/res_last) and busy
interface moore_seq_if import moore_seq_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);
  localparam int IDW = idx_w(NREQ);
  localparam int CNTW = $clog2(WIDTH + 1);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic fsm_reset;
  logic fsm_in;
  logic fsm_out;
  logic res_valid;
  logic res_ready;
  logic [IDW-1:0] res_id;
  logic [CNTW-1:0] res_count;
  logic res_last;
  logic busy;
  modport slave (
    input req_valid, req_data, fsm_out, res_ready,
    output req_ready, fsm_reset, fsm_in, res_valid, res_id, res_count, res_last, busy
  );
  modport master (
    output req_valid, req_data, fsm_out, res_ready,
    input req_ready, fsm_reset, fsm_in, res_valid, res_id, res_count, res_last, busy
  );
endinterface

// File: rtl/moore_seq_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req_i/last_i in, one-hot gnt_o and encoded idx_o out
module rr_arbiter import moore_seq_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);
  int j;
  logic hit;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit = 1'b0;
    j = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last_i) + i) % NREQ;
      if (!hit && req_i[j]) begin
        hit = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/moore_seq_scheduler.sv
// moore_seq_scheduler: round-robin shares one serial Moore FSM; ports clk, reset (async active-low), bus (moore_seq_if.slave)
module moore_seq_scheduler import moore_seq_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  moore_seq_if.slave bus
);
  localparam int IDW = idx_w(NREQ);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int XW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [IDW-1:0] last_q, last_d, id_q, id_d, gidx;
  logic [NREQ-1:0] gnt;
  logic [WIDTH-1:0] word_q, word_d;
  logic [XW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic lb_q, lb_d;
  logic samp;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i(bus.req_valid),
    .last_i(last_q),
    .gnt_o(gnt),
    .idx_o(gidx)
  );
  assign samp = (state_q == SHIFT && idx_q != XW'(WIDTH - 1)) || state_q == DRAIN;
  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.fsm_reset = !(state_q inside {SHIFT, DRAIN});
  assign bus.fsm_in = (state_q == SHIFT) & word_q[idx_q];
  assign bus.res_valid = state_q == DONE;
  assign bus.res_id = id_q;
  assign bus.res_count = cnt_q;
  assign bus.res_last = lb_q;
  assign bus.busy = state_q != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      id_q <= '0;
      word_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      lb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      word_q <= word_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      lb_q <= lb_d;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    word_d = word_q;
    idx_d = idx_q;
    cnt_d = samp ? cnt_q + CNTW'(bus.fsm_out) : cnt_q;
    lb_d = samp ? bus.fsm_out : lb_q;
    unique case (state_q)
      IDLE: if (|bus.req_valid) begin
        word_d = bus.req_data[gidx*WIDTH +: WIDTH];
        id_d = gidx;
        state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = '0;
        lb_d = 1'b0;
        idx_d = XW'(WIDTH - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        idx_d = idx_q - 1'b1;
        state_d = (idx_q == '0) ? DRAIN : SHIFT;
      end
      DRAIN: state_d = DONE;
      DONE: if (bus.res_ready) begin
        last_d = id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_moore_seq_scheduler.sv
// tb_moore_seq_scheduler: scoreboard bench with a registered stub FSM and a round-robin/popcount reference model
module tb_moore_seq_scheduler;
  import moore_seq_pkg::*;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {int id; int cnt; int last;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  exp_t me;
  int m_last = N - 1;
  int mw;
  logic [W-1:0] mword;
  int gcyc = 0;
  bit have_p = 0;
  bit chk_gap = 0;
  bit pv = 0;
  logic [N-1:0] acc;
  int snap;
  int order[5] = '{0, 1, 2, 3, 0};
  moore_seq_if #(.NREQ(N), .WIDTH(W)) bus();
  moore_seq_scheduler #(.NREQ(N), .WIDTH(W)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.fsm_out <= bus.fsm_reset ? 1'b0 : bus.fsm_in;
  function automatic void chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      m_last = N - 1;
      exp_q.delete();
      have_p = 0;
      pv = 0;
    end else begin
      if (|bus.req_ready) begin
        mw = -1;
        for (int k = 1; k <= N; k++)
          if (mw < 0 && bus.req_valid[(m_last + k) % N]) mw = (m_last + k) % N;
        chk("grant", int'(bus.req_ready), mw < 0 ? 0 : (1 << mw));
        if (mw >= 0) begin
          mword = bus.req_data[mw*W +: W];
          exp_q.push_back('{mw, $countones(mword), int'(mword[0])});
        end
        if (chk_gap && have_p) chk("gap", cyc - gcyc, W + 4);
        have_p = chk_gap;
        gcyc = cyc;
      end
      if (bus.res_valid && !pv) chk("latency", cyc - gcyc, W + 3);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          me = exp_q.pop_front();
          chk("res_id", int'(bus.res_id), me.id);
          chk("res_count", int'(bus.res_count), me.cnt);
          chk("res_last", int'(bus.res_last), me.last);
          m_last = me.id;
        end
      end
      pv = bus.res_valid;
    end
  end
  task automatic tick();
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask
  task automatic submit(input int id, input logic [W-1:0] w);
    bus.req_valid[id] = 1'b1;
    bus.req_data[id*W +: W] = w;
  endtask
  task automatic wait_acc(input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (acc == '0 && n < 40);
    if (acc == '0) chk({nm, "_timeout"}, 0, 1);
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    while ((bus.busy || bus.req_valid != '0 || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk({nm, "_timeout"}, 0, 1);
  endtask
  task automatic chk_rst(input string t);
    chk({t, "_req_ready"}, int'(bus.req_ready), 0);
    chk({t, "_fsm_reset"}, int'(bus.fsm_reset), 1);
    chk({t, "_fsm_in"}, int'(bus.fsm_in), 0);
    chk({t, "_res_valid"}, int'(bus.res_valid), 0);
    chk({t, "_res_id"}, int'(bus.res_id), 0);
    chk({t, "_res_count"}, int'(bus.res_count), 0);
    chk({t, "_res_last"}, int'(bus.res_last), 0);
    chk({t, "_busy"}, int'(bus.busy), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.res_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_rst("t1_rst");
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_fsm_reset", int'(bus.fsm_reset), 1);
      chk("t1_busy", int'(bus.busy), 0);
      chk("t1_req_ready", int'(bus.req_ready), 0);
    end
    @(posedge clk);
    #1;
    submit(2, 8'b1011_0010);
    tick();
    chk("t2_acc", int'(acc), 4'b0100);
    @(negedge clk);
    chk("t2_ready_drop", int'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    wait_idle("t2");
    do_reset();
    chk_gap = 1;
    for (int i = 0; i < N; i++) submit(i, W'($urandom));
    for (int j = 0; j < 5; j++) begin
      wait_acc("t3");
      chk("t3_order", int'(acc), 1 << order[j]);
      if (j < 4) submit(order[j], W'($urandom));
    end
    bus.req_valid = '0;
    wait_idle("t3");
    chk_gap = 0;
    bus.res_ready = 1'b0;
    submit(0, W'($urandom));
    wait_acc("t4");
    submit(1, W'($urandom));
    for (int n = 0; n < 40 && !bus.res_valid; n++) tick();
    chk("t4_reach_done", int'(bus.res_valid), 1);
    snap = int'(bus.res_count);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", int'(bus.res_valid), 1);
      chk("t4_hold_count", int'(bus.res_count), snap);
      chk("t4_no_grant", int'(bus.req_ready), 0);
      chk("t4_fsm_reset", int'(bus.fsm_reset), 1);
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    tick();
    chk("t4_released", int'(bus.res_valid), 0);
    chk("t4_idle", int'(bus.busy), 0);
    wait_idle("t4");
    submit(1, 8'hFF);
    wait_acc("t5");
    chk("t5_acc", int'(acc), 4'b0010);
    repeat (4) tick();
    chk("t5_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk_rst("t5_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) submit(i, W'($urandom));
    wait_acc("t5_after");
    chk("t5_first", int'(acc), 4'b0001);
    bus.req_valid = '0;
    wait_idle("t5");
    submit(3, 8'h00);
    wait_idle("t6a");
    submit(3, 8'hFF);
    wait_idle("t6b");
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(9) < 3) submit(i, W'($urandom));
      bus.res_ready = ($urandom_range(3) != 0);
      tick();
    end
    bus.res_ready = 1'b1;
    wait_idle("rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
